// File: rtl/sample_trigger_if.sv
// Controller/probe-side bundle for sample_trigger: arm and config inputs in, capture stream and status out.
// No handshake: sample_valid is a strobe with no backpressure.
interface sample_trigger_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                   arm;
  logic [23:0]            divider;
  logic [DATA_WIDTH-1:0]  probe;
  logic [DATA_WIDTH-1:0]  trig_mask;
  logic [DATA_WIDTH-1:0]  trig_value;
  logic [COUNT_WIDTH-1:0] capture_len;
  logic                   run;
  logic                   sample_valid;
  logic [DATA_WIDTH-1:0]  sample_data;
  logic                   done;

  modport master (
    output arm, divider, probe, trig_mask, trig_value, capture_len,
    input  run, sample_valid, sample_data, done
  );

  modport slave (
    input  arm, divider, probe, trig_mask, trig_value, capture_len,
    output run, sample_valid, sample_data, done
  );
endinterface

// File: rtl/sample_trigger.sv
// Logic-analyzer trigger/capture: arms on arm rising edge, triggers on masked match, emits capture_len samples.
// 2-cycle pin-to-compare latency, all outputs registered; sample stream has no backpressure.
module sample_trigger #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             int_reset,
  sample_trigger_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [23:0]            count_q, count_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   arm_prev_q, arm_prev_d;
  logic [DATA_WIDTH-1:0]  s1_q, s1_d;
  logic [DATA_WIDTH-1:0]  psync_q, psync_d;
  logic                   run_q, run_d;
  logic                   sv_q, sv_d;
  logic                   done_q, done_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;

  logic                   tick;
  logic                   match;
  logic                   arm_rise;
  logic [COUNT_WIDTH-1:0] eff_len;

  assign tick     = (count_q >= bus.divider);
  assign match    = (((psync_q ^ bus.trig_value) & bus.trig_mask) == '0);
  assign arm_rise = bus.arm & ~arm_prev_q;
  assign eff_len  = (bus.capture_len == '0) ? COUNT_WIDTH'(1) : bus.capture_len;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    cnt_d      = cnt_q;
    arm_prev_d = bus.arm;
    s1_d       = bus.probe;
    psync_d    = s1_q;
    run_d      = 1'b0;
    sv_d       = 1'b0;
    done_d     = 1'b0;
    data_d     = data_q;

    case (state_q)
      IDLE: begin
        count_d = '0;
        cnt_d   = '0;
        if (arm_rise) state_d = ARMED;
      end
      ARMED: begin
        if (tick) begin
          count_d = '0;
          if (match) begin
            // Trigger word is itself sample 1.
            state_d = CAPTURE;
            run_d   = 1'b1;
            sv_d    = 1'b1;
            data_d  = psync_q;
            cnt_d   = COUNT_WIDTH'(1);
          end
        end else begin
          count_d = count_q + 24'd1;
        end
      end
      CAPTURE: begin
        run_d = 1'b1;
        if (cnt_q >= eff_len) begin
          state_d = DONE;
          run_d   = 1'b0;
          done_d  = 1'b1;
          count_d = '0;
        end else if (tick) begin
          count_d = '0;
          sv_d    = 1'b1;
          data_d  = psync_q;
          cnt_d   = cnt_q + COUNT_WIDTH'(1);
        end else begin
          count_d = count_q + 24'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = '0;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    if (int_reset) begin
      state_d    = IDLE;
      count_d    = '0;
      cnt_d      = '0;
      arm_prev_d = 1'b0;
      run_d      = 1'b0;
      sv_d       = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      cnt_q      <= '0;
      arm_prev_q <= 1'b0;
      s1_q       <= '0;
      psync_q    <= '0;
      run_q      <= 1'b0;
      sv_q       <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      arm_prev_q <= arm_prev_d;
      s1_q       <= s1_d;
      psync_q    <= psync_d;
      run_q      <= run_d;
      sv_q       <= sv_d;
      done_q     <= done_d;
      data_q     <= data_d;
    end
  end

  assign bus.run          = run_q;
  assign bus.sample_valid = sv_q;
  assign bus.sample_data  = data_q;
  assign bus.done         = done_q;

endmodule

// File: doc/sample_trigger.md
SAMPLE_TRIGGER -- requirements
Module: sample_trigger

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, the probe channel count.
REQ-002 The module SHALL have parameter COUNT_WIDTH, default 16, the capture length counter width.
REQ-003 The module SHALL have port clock, input, 1, the single system clock; all logic is rising-edge.
REQ-004 The module SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-005 The module SHALL have port int_reset, input, 1, a synchronous soft reset from the controller.
REQ-006 The module SHALL have port arm, input, 1, the arm request from the controller, rising-edge detected.
REQ-007 The module SHALL have port divider, input, 24, the sample period minus one in clock cycles.
REQ-008 The module SHALL have port probe, input, DATA_WIDTH, the asynchronous probe pins.
REQ-009 The module SHALL have port trig_mask, input, DATA_WIDTH, where 1 marks a channel included in the trigger compare.
REQ-010 The module SHALL have port trig_value, input, DATA_WIDTH, the required level on each masked channel.
REQ-011 The module SHALL have port capture_len, input, COUNT_WIDTH, the number of samples to emit after the trigger.
REQ-012 The module SHALL have port run, output, 1, high while capturing, as status to the controller.
REQ-013 The module SHALL have port sample_valid, output, 1, a one-cycle strobe qualifying sample_data.
REQ-014 The module SHALL have port sample_data, output, DATA_WIDTH, the captured probe word.
REQ-015 The module SHALL have port done, output, 1, a one-cycle pulse when capture completes.

Function
REQ-016 probe SHALL pass through a 2-flop synchronizer; the synchronized value (psync) is used for all compare and capture, giving 2 cycles of pin-to-psync latency.
REQ-017 The prescaler SHALL be a 24-bit up-counter: tick=1 when count>=divider, then count<=0, else count<=count+1; divider=0 gives a tick every cycle.
REQ-018 The prescaler SHALL be cleared to 0 on entry to ARMED and SHALL hold 0 in IDLE and DONE.
REQ-019 The FSM SHALL have states IDLE, ARMED, CAPTURE and DONE.
REQ-020 IDLE SHALL go to ARMED on the cycle after arm rises from 0 to 1; a held-high arm SHALL NOT re-arm.
REQ-021 ARMED SHALL go to CAPTURE on a tick where (psync & trig_mask)==(trig_value & trig_mask); the trigger sample SHALL be emitted as sample 1 with sample_valid in the same cycle as the transition.
REQ-022 trig_mask=0 SHALL trigger on the first tick after arming.
REQ-023 CAPTURE SHALL emit psync with sample_valid=1 on each tick and count samples, trigger sample included.
REQ-024 When the emitted count equals capture_len, the FSM SHALL go to DONE and SHALL NOT emit further samples.
REQ-025 capture_len=0 SHALL be treated as 1: the trigger sample only.
REQ-026 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-027 run SHALL be 1 exactly while the state is CAPTURE.
REQ-028 sample_data SHALL hold its last value when sample_valid=0.
REQ-029 capture_len and the trigger inputs SHALL be sampled live; a divider change takes effect at the next compare.
REQ-030 int_reset=1 SHALL force IDLE, clear the prescaler, the sample counter and the arm edge detector, and deassert run, sample_valid and done in the next cycle.
REQ-031 int_reset SHALL have priority over arm and tick in the same cycle.

Reset
REQ-032 reset_n=0 SHALL asynchronously force state=IDLE, run=0, sample_valid=0, done=0, sample_data=0, prescaler=0, sample counter=0, synchronizer=0 and arm edge register=0.
REQ-033 Outputs SHALL leave reset values only on the first clock edge after reset_n deasserts.

Verification
REQ-034 divider=0, mask=0x00, capture_len=4, pulse arm -> run high 1 cycle after the arm edge, 4 consecutive sample_valid cycles, then done for 1 cycle, then run=0.
REQ-035 divider=3, mask=0x01, value=0x01, probe=0x00 then bit0=1 -> no samples while bit0=0; first sample_valid 2-6 cycles after bit0 rises with sample_data[0]=1, then samples spaced exactly 4 cycles apart.
REQ-036 capture_len=0, mask=0 -> exactly 1 sample_valid followed by done.
REQ-037 arm held high through two full captures -> only one capture occurs; a second capture occurs only after arm goes 0 then 1.
REQ-038 int_reset asserted mid-CAPTURE (after 2 of 10 samples) -> next cycle run=0, no further samples, no done; a re-arm starts a fresh 10-sample count.
REQ-039 reset_n pulsed low between clock edges during CAPTURE -> run and sample_valid drop immediately without a clock, and the state is IDLE.
